// File: rtl/bird_ctrl.sv
// bird_ctrl: bird vertical motion with flap edge detection, gravity, ceiling clamp and sticky floor hit
module bird_ctrl #(
  parameter int Y_START  = 300,
  parameter int Y_MAX    = 584,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -8,
  parameter int VMAX     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] state,
  input  logic       mouse_left,
  output logic [9:0] bird_y,
  output logic [5:0] bird_vel,
  output logic       hit_bound
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FLY  = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;
  localparam logic signed [10:0] FLAP_S = FLAP_VEL[10:0];
  localparam logic signed [10:0] GRAV_S = GRAVITY[10:0];
  localparam logic signed [10:0] VMAX_S = VMAX[10:0];
  localparam logic signed [10:0] YMAX_S = Y_MAX[10:0];
  localparam logic [9:0] Y0 = Y_START[9:0];
  logic [1:0] mode;
  logic [9:0] y_q, y_d;
  logic [5:0] vel_q, vel_d;
  logic hit_q, hit_d, pend_q, pend_d, mouse_q, pulse, flap, ceil, floor_hit;
  logic signed [10:0] v_grav, v_new, y_new;
  always_comb begin
    mode = (state == 2'b01 && !hit_q) ? FLY : (state == 2'b10 || state == 2'b01) ? DEAD : IDLE;
    pulse = mouse_left & ~mouse_q;
    flap = pend_q | pulse;
    v_grav = {{5{vel_q[5]}}, vel_q} + GRAV_S;
    v_new = flap ? FLAP_S : (v_grav > VMAX_S ? VMAX_S : v_grav);
    y_new = {1'b0, y_q} + v_new;
    ceil = y_new[10];
    floor_hit = !ceil && y_new >= YMAX_S;
    y_d = y_q;
    vel_d = vel_q;
    hit_d = hit_q;
    pend_d = pend_q;
    if (mode == IDLE) begin
      y_d = Y0;
      vel_d = '0;
      hit_d = 1'b0;
      pend_d = 1'b0;
    end else if (mode == DEAD) begin
      pend_d = 1'b0;
    end else if (!frame_tick) begin
      pend_d = flap;
    end else begin
      pend_d = 1'b0;
      y_d = ceil ? '0 : floor_hit ? YMAX_S[9:0] : y_new[9:0];
      vel_d = (ceil || floor_hit) ? '0 : v_new[5:0];
      hit_d = floor_hit;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q <= Y0;
      vel_q <= '0;
      hit_q <= 1'b0;
      pend_q <= 1'b0;
      mouse_q <= 1'b0;
    end else begin
      y_q <= y_d;
      vel_q <= vel_d;
      hit_q <= hit_d;
      pend_q <= pend_d;
      mouse_q <= mouse_left;
    end
  end
  assign bird_y = y_q;
  assign bird_vel = vel_q;
  assign hit_bound = hit_q;
endmodule

// File: doc/bird_ctrl.md
BIRD_CTRL -- requirements
Module: bird_ctrl

Interface
REQ-001 The block SHALL have parameter Y_START, default 300, meaning the bird's initial top-edge row in pixels.
REQ-002 The block SHALL have parameter Y_MAX, default 584, meaning the floor row limit (600-line screen minus 16-pixel bird).
REQ-003 The block SHALL have parameter GRAVITY, default 1, meaning the velocity increment per frame in px/frame.
REQ-004 The block SHALL have parameter FLAP_VEL, default -8, meaning the velocity loaded on a flap in px/frame, signed.
REQ-005 The block SHALL have parameter VMAX, default 10, meaning the terminal downward velocity in px/frame.
REQ-006 The block SHALL have port clk, input, 1 bit: posedge-active clock.
REQ-007 The block SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-008 The block SHALL have port frame_tick, input, 1 bit: single-cycle pulse, once per video frame.
REQ-009 The block SHALL have port state, input, 2 bits: game state with 00=START, 01=GAME, 10=GAMEOVER, and 11 treated as START.
REQ-010 The block SHALL have port mouse_left, input, 1 bit: raw left-button level.
REQ-011 The block SHALL have port bird_y, output, 10 bits: bird top-edge row, unsigned.
REQ-012 The block SHALL have port bird_vel, output, 6 bits: current velocity, two's complement, positive meaning downward.
REQ-013 The block SHALL have port hit_bound, output, 1 bit: floor-collision flag, sticky, intended for ORing into the collision input of the game FSM.

Function
REQ-014 The block SHALL contain an internal FSM with states IDLE, FLY and DEAD.
REQ-015 The FSM SHALL enter IDLE whenever state is START (or 11), FLY whenever state is GAME and hit_bound is 0, and DEAD when state is GAMEOVER or hit_bound is 1.
REQ-016 In IDLE, every clock, the block SHALL set bird_y=Y_START, bird_vel=0 and hit_bound=0, and clear the flap pending flag.
REQ-017 Flap detection SHALL use a registered rising edge: pulse = mouse_left & ~mouse_left_d.
REQ-018 A flap pulse in FLY SHALL set the pending flag, which holds until consumed by the next frame_tick.
REQ-019 Multiple pulses between ticks SHALL collapse into a single pending flap.
REQ-020 A pulse coincident with frame_tick SHALL be consumed by that tick.
REQ-021 The bird SHALL update only on a frame_tick while in FLY; between ticks bird_y and bird_vel SHALL hold.
REQ-022 On an update, the velocity SHALL be computed as v' = FLAP_VEL if a flap is pending, otherwise min(bird_vel+GRAVITY, VMAX); the pending flag SHALL clear in the same cycle.
REQ-023 On an update, the position SHALL be computed as y' = bird_y + sign-extended v', using 11-bit signed arithmetic.
REQ-024 If y' < 0, the block SHALL set bird_y=0 and bird_vel=0 (ceiling clamp, no collision).
REQ-025 If y' >= Y_MAX, the block SHALL set bird_y=Y_MAX, bird_vel=0 and hit_bound=1.
REQ-026 If neither clamp applies, the block SHALL set bird_y=y' and bird_vel=v'.
REQ-027 The update latency SHALL be that outputs reflect a tick on the clock edge that samples frame_tick high (1 cycle).
REQ-028 hit_bound SHALL stay 1 through DEAD until the FSM returns to IDLE.
REQ-029 In DEAD, bird_y and bird_vel SHALL be frozen and flap pulses ignored.
REQ-030 A change of state between ticks SHALL take effect on the next clock edge, regardless of frame_tick.

Reset
REQ-031 While rst=0, asynchronously, the block SHALL force FSM=IDLE, bird_y=Y_START, bird_vel=0, hit_bound=0, pending=0 and mouse_left_d=0.
REQ-032 Reset asserted mid-flight SHALL abort the update, and no partial update SHALL be visible.
REQ-033 On rst release, the block SHALL resume at the first posedge with state evaluated normally.

Verification
REQ-034 Scenario: state=GAME, no clicks, 3 ticks from reset -> bird_vel 1,2,3 and bird_y 301,303,306.
REQ-035 Scenario: state=GAME, click once, then 1 tick -> bird_vel=-8 and bird_y=292; the next tick -> bird_vel=-7 and bird_y=285.
REQ-036 Scenario: 3 clicks between ticks, mouse held high across a tick -> exactly one flap applied; a held button SHALL NOT re-flap.
REQ-037 Scenario: free fall from 300 -> bird_vel saturates at 10, bird_y clamps at 584, hit_bound=1 on that tick and stays 1; further ticks do not change bird_y.
REQ-038 Scenario: repeated clicks near the top (bird_y=4) -> bird_y=0, bird_vel=0, hit_bound stays 0.
REQ-039 Scenario: state GAMEOVER then START -> outputs frozen in GAMEOVER; in START, bird_y=300, bird_vel=0 and hit_bound=0 one cycle later; async rst low mid-tick -> immediate reset values without waiting for clk.
